// File: rtl/taylor_range_reduce_if.sv
// Request/response and sine-core signals of taylor_range_reduce, bundled with modports.
// mode_in exists only when TAYLOR_COS_EN is defined.
interface taylor_range_reduce_if #(
  parameter int W_IN   = 16,
  parameter int W_CORE = 12
);
  logic              start_in;
  logic [W_IN-1:0]   angle_in;
`ifdef TAYLOR_COS_EN
  logic              mode_in;
`endif
  logic              ready_out;
  logic [W_CORE-1:0] sin_out;
  logic              busy_out;
  logic [1:0]        quadrant_out;
  logic              core_start_out;
  logic [W_CORE-1:0] core_x_out;
  logic              core_ready_in;
  logic [W_CORE-1:0] core_sin_in;

  modport slave (
`ifdef TAYLOR_COS_EN
    input  mode_in,
`endif
    input  start_in, angle_in, core_ready_in, core_sin_in,
    output ready_out, sin_out, busy_out, quadrant_out, core_start_out, core_x_out
  );

  modport master (
`ifdef TAYLOR_COS_EN
    output mode_in,
`endif
    output start_in, angle_in, core_ready_in, core_sin_in,
    input  ready_out, sin_out, busy_out, quadrant_out, core_start_out, core_x_out
  );
endinterface

// File: rtl/taylor_range_reduce.sv
// Wraps a wide fixed-point angle into [-pi,pi], folds it into [-pi/2,pi/2] and runs one
// sine-core transaction. Define TAYLOR_COS_EN to add mode_in (cosine via +pi/2 offset).
module taylor_range_reduce #(
  parameter int W_IN    = 16,
  parameter int W_CORE  = 12,
  parameter int TWO_PI  = 6434,
  parameter int PI      = 3217,
  parameter int HALF_PI = 1608
) (
  input logic                   clock,
  input logic                   reset,
  taylor_range_reduce_if.slave  bus
);
  localparam int W_ACC = W_IN + 2;

  localparam logic signed [W_ACC-1:0] TWO_PI_A   = W_ACC'(TWO_PI);
  localparam logic signed [W_ACC-1:0] PI_A       = W_ACC'(PI);
  localparam logic signed [W_ACC-1:0] NEG_PI_A   = -W_ACC'(PI);
  localparam logic signed [W_ACC-1:0] HALF_PI_A  = W_ACC'(HALF_PI);
  localparam logic signed [W_ACC-1:0] NEG_HALF_A = -W_ACC'(HALF_PI);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WRAP = 3'd2;
  localparam logic [2:0] S_FOLD = 3'd3;
  localparam logic [2:0] S_CALL = 3'd4;
  localparam logic [2:0] S_ARM  = 3'd5;
  localparam logic [2:0] S_WAIT = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  logic [2:0]              state_q, state_d;
  logic signed [W_ACC-1:0] acc_q, acc_d;
  logic [W_CORE-1:0]       x_q, x_d;
  logic [1:0]              quad_q, quad_d;
  logic [1:0]              quad_out_q, quad_out_d;
  logic                    ready_q, ready_d;
  logic [W_CORE-1:0]       sin_q, sin_d;
  logic                    core_start_q, core_start_d;
  logic signed [W_ACC-1:0] load_val;

`ifdef TAYLOR_COS_EN
  logic mode_q, mode_d;

  always_comb begin
    load_val = W_ACC'($signed(bus.angle_in));
    if (mode_q) load_val = load_val + HALF_PI_A;
  end
`else
  always_comb begin
    load_val = W_ACC'($signed(bus.angle_in));
  end
`endif

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    x_d          = x_q;
    quad_d       = quad_q;
    quad_out_d   = quad_out_q;
    ready_d      = ready_q;
    sin_d        = sin_q;
    core_start_d = core_start_q;
`ifdef TAYLOR_COS_EN
    mode_d       = mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start_in) begin
          ready_d = 1'b0;
          state_d = S_LOAD;
`ifdef TAYLOR_COS_EN
          mode_d  = bus.mode_in;
`endif
        end
      end
      S_LOAD: begin
        acc_d   = load_val;
        state_d = S_WRAP;
      end
      S_WRAP: begin
        if (acc_q > PI_A)          acc_d = acc_q - TWO_PI_A;
        else if (acc_q < NEG_PI_A) acc_d = acc_q + TWO_PI_A;
        else                       state_d = S_FOLD;
      end
      // Folded value always fits in [-HALF_PI, HALF_PI], so plain truncation is safe.
      S_FOLD: begin
        if (acc_q > HALF_PI_A) begin
          x_d    = W_CORE'(PI_A - acc_q);
          quad_d = 2'd1;
        end else if (acc_q < NEG_HALF_A) begin
          x_d    = W_CORE'(NEG_PI_A - acc_q);
          quad_d = 2'd2;
        end else begin
          x_d    = W_CORE'(acc_q);
          quad_d = acc_q[W_ACC-1] ? 2'd3 : 2'd0;
        end
        state_d = S_CALL;
      end
      S_CALL: begin
        core_start_d = 1'b1;
        state_d      = S_ARM;
      end
      // The core's ready from the previous result is stale until it drops once.
      S_ARM: begin
        if (!bus.core_ready_in) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.core_ready_in) begin
          sin_d        = bus.core_sin_in;
          quad_out_d   = quad_q;
          ready_d      = 1'b1;
          core_start_d = 1'b0;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.start_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      x_q          <= '0;
      quad_q       <= '0;
      quad_out_q   <= '0;
      ready_q      <= 1'b0;
      sin_q        <= '0;
      core_start_q <= 1'b0;
`ifdef TAYLOR_COS_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      x_q          <= x_d;
      quad_q       <= quad_d;
      quad_out_q   <= quad_out_d;
      ready_q      <= ready_d;
      sin_q        <= sin_d;
      core_start_q <= core_start_d;
`ifdef TAYLOR_COS_EN
      mode_q       <= mode_d;
`endif
    end
  end

  assign bus.ready_out      = ready_q;
  assign bus.sin_out        = sin_q;
  assign bus.quadrant_out   = quad_out_q;
  assign bus.core_start_out = core_start_q;
  assign bus.core_x_out     = x_q;
  assign bus.busy_out       = (state_q != S_IDLE) && (state_q != S_DONE);
endmodule

// File: tb/tb_taylor_range_reduce.sv
// Directed bench for taylor_range_reduce with a behavioural sine-core model that
// holds a stale ready for two cycles and then answers after a fixed delay.
module tb_taylor_range_reduce;
  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  taylor_range_reduce_if #(.W_IN(16), .W_CORE(12)) bus ();

  taylor_range_reduce dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One full transaction: start, count wrap steps via core_start latency, play the core.
  task automatic applyStimulus(input string tag, input int angle, input bit mode,
                               input int expSteps, input int expX, input int expQ,
                               input logic [11:0] sinVal);
    int cycles;
    bit early;
    @(negedge clock);
    bus.angle_in    = 16'(angle);
    bus.core_sin_in = 12'hEEE;
`ifdef TAYLOR_COS_EN
    bus.mode_in     = mode;
`else
    if (mode) $display("[TB] cosine mode requested without TAYLOR_COS_EN, running sine");
`endif
    bus.start_in    = 1'b1;
    cycles = 0;
    do begin
      @(posedge clock); #1;
      cycles++;
      if (cycles == 1) begin
        checkOutput({tag, " ready cleared"}, int'(bus.ready_out), 0);
        checkOutput({tag, " busy"}, int'(bus.busy_out), 1);
      end
    end while (!bus.core_start_out && cycles < 60);
    checkOutput({tag, " wrap steps"}, cycles - 5, expSteps);
    checkOutput({tag, " core_x"}, int'($signed(bus.core_x_out)), expX);

    early = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
      if (bus.ready_out) early = 1'b1;
    end
    bus.core_ready_in = 1'b0;
    repeat (15) begin
      @(posedge clock); #1;
      if (bus.ready_out) early = 1'b1;
    end
    bus.core_sin_in   = sinVal;
    bus.core_ready_in = 1'b1;
    checkOutput({tag, " early capture"}, int'(early), 0);

    cycles = 0;
    do begin
      @(posedge clock); #1;
      cycles++;
    end while (!bus.ready_out && cycles < 10);
    checkOutput({tag, " ready"}, int'(bus.ready_out), 1);
    checkOutput({tag, " sin"}, int'(bus.sin_out), int'(sinVal));
    checkOutput({tag, " quadrant"}, int'(bus.quadrant_out), expQ);
    checkOutput({tag, " core_start low"}, int'(bus.core_start_out), 0);

    bus.start_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput({tag, " idle ready hold"}, int'(bus.ready_out), 1);
    checkOutput({tag, " idle sin hold"}, int'(bus.sin_out), int'(sinVal));
    checkOutput({tag, " idle busy"}, int'(bus.busy_out), 0);
  endtask

  initial begin
    int cycles;
    reset             = 1'b1;
    bus.start_in      = 1'b0;
    bus.angle_in      = '0;
    bus.core_ready_in = 1'b1;
    bus.core_sin_in   = 12'hEEE;
`ifdef TAYLOR_COS_EN
    bus.mode_in       = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset ready", int'(bus.ready_out), 0);
    checkOutput("reset sin", int'(bus.sin_out), 0);
    checkOutput("reset quadrant", int'(bus.quadrant_out), 0);
    checkOutput("reset core_start", int'(bus.core_start_out), 0);
    checkOutput("reset core_x", int'(bus.core_x_out), 0);
    checkOutput("reset busy", int'(bus.busy_out), 0);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus("a0",      0,      1'b0, 0,     0, 0, 12'h000);
    applyStimulus("a2500",   2500,   1'b0, 0,   717, 1, 12'h1A5);
    applyStimulus("a3217",   3217,   1'b0, 0,     0, 1, 12'h012);
    applyStimulus("a7000",   7000,   1'b0, 1,   566, 0, 12'h345);
    applyStimulus("aMin",    -32768, 1'b0, 5,  -598, 3, 12'hC21);
    applyStimulus("aMax",    32767,  1'b0, 5,   597, 0, 12'h3DE);
    applyStimulus("a1608",   1608,   1'b0, 0,  1608, 0, 12'h400);
    applyStimulus("aN1608",  -1608,  1'b0, 0, -1608, 3, 12'hC00);
    applyStimulus("aN3217",  -3217,  1'b0, 0,     0, 2, 12'h001);
    applyStimulus("aN2500",  -2500,  1'b0, 0,  -717, 2, 12'hE5B);

    // Abort mid-WAIT with a reset; outputs from the previous result must clear.
    @(negedge clock);
    bus.angle_in    = 16'd7000;
    bus.core_sin_in = 12'hEEE;
    bus.start_in    = 1'b1;
    cycles = 0;
    do begin
      @(posedge clock); #1;
      cycles++;
    end while (!bus.core_start_out && cycles < 60);
    checkOutput("rst core_start seen", int'(bus.core_start_out), 1);
    repeat (2) @(posedge clock);
    #1;
    bus.core_ready_in = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("rst core_start", int'(bus.core_start_out), 0);
    checkOutput("rst ready", int'(bus.ready_out), 0);
    checkOutput("rst sin", int'(bus.sin_out), 0);
    checkOutput("rst busy", int'(bus.busy_out), 0);
    checkOutput("rst quadrant", int'(bus.quadrant_out), 0);
    checkOutput("rst core_x", int'(bus.core_x_out), 0);
    @(negedge clock);
    reset             = 1'b0;
    bus.start_in      = 1'b0;
    bus.core_ready_in = 1'b1;

    applyStimulus("post rst", 7000, 1'b0, 1, 566, 0, 12'h0F0);
`ifdef TAYLOR_COS_EN
    applyStimulus("cos0", 0, 1'b1, 0, 1608, 0, 12'h3FF);
    applyStimulus("sin after cos", 2500, 1'b0, 0, 717, 1, 12'h1A5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/taylor_range_reduce.md
Name: taylor_range_reduce

Overview:
- Upstream front-end for the 12-bit Taylor sine core.
- Accepts a wide signed fixed-point angle (scale 1024, 10 fractional bits) and wraps it into [-pi, pi] by iterative +/-2pi steps.
- Folds the wrapped angle into [-pi/2, pi/2] using sin(pi-x)=sin(x), then runs one start/ready transaction with the sine core and returns its result.
- Sits between the AXI register wrapper and the sine core.

Parameters:
- W_IN, 16, input angle width (signed, 10 fractional bits)
- W_CORE, 12, sine core operand/result width
- TWO_PI, 6434, 2pi x 1024
- PI, 3217, pi x 1024
- HALF_PI, 1608, pi/2 x 1024

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_in  in  1  level request; sampled only in IDLE
- angle_in  in  W_IN  signed angle, captured in LOAD
- ready_out  out  1  result valid; held until next accepted start
- sin_out  out  W_CORE  signed sine result
- busy_out  out  1  high in every state except IDLE and DONE
- quadrant_out  out  2  0:[0,pi/2] 1:(pi/2,pi] 2:[-pi,-pi/2) 3:[-pi/2,0); valid with ready_out
- core_start_out  out  1  start to sine core
- core_x_out  out  W_CORE  folded angle to sine core
- core_ready_in  in  1  sine core ready
- core_sin_in  in  W_CORE  sine core result

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-high, reset.
- Reset values:
  - ready_out=0, sin_out=0, quadrant_out=0, core_start_out=0, core_x_out=0, busy_out=0; state=IDLE.
  - Reset in any state, including mid-WAIT, aborts the operation; core_start_out is 0 on the cycle after reset is sampled.
- Internal accumulator acc: W_IN+2 bits signed; no overflow possible.
- IDLE:
  - start_in=1: ready_out<=0, go LOAD.
  - Otherwise stay; ready_out and sin_out keep their last values.
- LOAD: acc<=sign-extended angle_in; go WRAP.
- WRAP (one add/sub per cycle):
  - acc>PI: acc<=acc-TWO_PI; stay.
  - acc<-PI: acc<=acc+TWO_PI; stay.
  - Otherwise go FOLD.
  - Boundaries: acc==PI and acc==-PI exit unchanged. Worst case for W_IN=16 is 5 steps (32767 -> 597; -32768 -> -598).
- FOLD:
  - acc>HALF_PI: core_x_out<=PI-acc, quadrant 1.
  - acc<-HALF_PI: core_x_out<=-PI-acc, quadrant 2.
  - Otherwise core_x_out<=acc; quadrant 0 if acc>=0, else 3.
  - Result always lies in [-1608,1608]; truncate to W_CORE bits with no saturation needed.
  - Go CALL.
- CALL: core_start_out<=1; go ARM.
- ARM: wait for core_ready_in==0. The core clears its ready flag one cycle after seeing start; this prevents capturing a stale result. Then go WAIT.
- WAIT: on core_ready_in==1: sin_out<=core_sin_in, quadrant_out<=latched quadrant, ready_out<=1, core_start_out<=0; go DONE.
- DONE:
  - start_in==0: go IDLE.
  - Otherwise stay. ready_out stays 1 in both cases.
- start_in dropping mid-operation does not abort; the operation completes and DONE exits the next cycle.
- start_in is ignored outside IDLE and DONE.
- Block latency, start sampled to ready_out=1, excluding core time: 1 (LOAD) + (n+1) WRAP + 1 (FOLD) + 1 (CALL) + ARM/WAIT cycles; n = number of wrap steps.
- core_x_out is held stable from FOLD until the next LOAD.

Optional Feature:
- Macro: TAYLOR_COS_EN.
- Defined:
  - Extra input port mode_in (1 bit), sampled with start_in in IDLE.
  - mode_in=1: LOAD sets acc<=sign-extended angle_in+HALF_PI, giving cos(x)=sin(x+pi/2).
  - mode_in=0: sine behaviour as above.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
- angle_in=0 -> 0 WRAP steps; core_x_out=0, quadrant_out=0; core model returns 0 -> sin_out=0, ready_out=1.
- angle_in=2500 -> core_x_out=717, quadrant_out=1. angle_in=3217 -> core_x_out=0, quadrant_out=1.
- angle_in=7000 -> exactly 1 WRAP step; core_x_out=566, quadrant_out=0.
- angle_in=-32768 -> exactly 5 WRAP steps; core_x_out=-598, quadrant_out=3. angle_in=32767 -> core_x_out=597.
- Core model holds stale core_ready_in=1 for 2 cycles after core_start_out rises, then 0 for 15 cycles, then 1 with core_sin_in=12'h1A5 -> sin_out=12'h1A5; not captured early.
- Reset asserted during WAIT -> next cycle core_start_out=0, ready_out=0, sin_out=0, busy_out=0. With TAYLOR_COS_EN and mode_in=1, angle_in=0 -> core_x_out=1608, quadrant_out=0.
